// File: rtl/register_file_if.sv
// Decode-stage register file bus: read addresses/data plus writeback port.
// Master drives addresses, write enable and write data; slave returns reads.
interface register_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wen;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] din;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;

  modport master (
    output wen, rd, rs1, rs2, din,
    input  r1, r2
  );

  modport slave (
    input  wen, rd, rs1, rs2, din,
    output r1, r2
  );
endinterface

// File: rtl/register_file.sv
// RV32I integer register file: 2 async read ports, 1 sync write, x0 = 0.
// Optional same-cycle write-to-read forwarding under WRITE_BYPASS_EN.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  register_file_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] we;

  // Per-entry enable keeps an unknown wen confined to regs[rd].
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      we[i]     = bus.wen && (bus.rd == AW'(i)) && (i != 0);
      regs_d[i] = we[i] ? bus.din : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [AW-1:0] a
  );
    logic [XLEN-1:0] v;
    v = (a == '0) ? '0 : regs_q[a];
`ifdef WRITE_BYPASS_EN
    if (bus.wen && (bus.rd != '0) && (bus.rd == a)) begin
      v = bus.din;
    end
`endif
    if (!rst_n) begin
      v = '0;
    end
    return v;
  endfunction

  assign bus.r1 = rd_port(bus.rs1);
  assign bus.r2 = rd_port(bus.rs2);
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array reference model.
module tb_register_file;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [XLEN-1:0] mem [32];

  register_file_if #(.XLEN(XLEN), .AW(AW)) bus ();

  register_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model_rd(input int a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? 32'h0 : mem[a];
`ifdef WRITE_BYPASS_EN
    if (rst_n && bus.wen && bus.rd != 0 && int'(bus.rd) == a) v = bus.din;
`endif
    if (!rst_n) v = 32'h0;
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.wen && bus.rd != 0) mem[bus.rd] = bus.din;
    #1;
  endtask

  task automatic idle();
    bus.wen = 1'b0;
    bus.rd  = '0;
    bus.din = '0;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    for (int a = 0; a < 32; a++) begin
      bus.rs1 = AW'(a);
      bus.rs2 = AW'(31 - a);
      #1;
      checks++;
      if (bus.r1 !== 32'h0 || bus.r2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d r1=%h r2=%h want 0", a, bus.r1, bus.r2);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd10; bus.din = 32'hBABEFACE;
    tick();
    idle();
    bus.rs2 = 5'd10; bus.rs1 = 5'd2;
    #1;
    checks++;
    if (bus.r2 !== 32'hBABEFACE || bus.r1 !== 32'h0) begin
      errors++;
      $display("FAIL write_r10 r2=%h r1=%h want BABEFACE/0", bus.r2, bus.r1);
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd2; bus.din = 32'hBABEFACE;
    tick();
    idle();
    bus.rs1 = 5'd2; bus.rs2 = 5'd2;
    #1;
    checks++;
    if (bus.r1 !== 32'hBABEFACE || bus.r2 !== 32'hBABEFACE) begin
      errors++;
      $display("FAIL same_addr r1=%h r2=%h want BABEFACE", bus.r1, bus.r2);
    end
    bus.rs1 = 5'd10;
    #1;
    checks++;
    if (bus.r1 !== 32'hBABEFACE) begin
      errors++;
      $display("FAIL reg10_kept r1=%h want BABEFACE", bus.r1);
    end
  endtask

  task automatic test_x0_wen();
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd0; bus.din = 32'hFFFFFFFF;
    tick();
    idle();
    bus.rs1 = 5'd0;
    #1;
    checks++;
    if (bus.r1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_write r1=%h want 0", bus.r1);
    end
    @(negedge clk);
    bus.wen = 1'b0; bus.rd = 5'd5; bus.din = 32'h1234;
    tick();
    idle();
    bus.rs1 = 5'd5;
    #1;
    checks++;
    if (bus.r1 !== 32'h0) begin
      errors++;
      $display("FAIL wen0_write r1=%h want 0", bus.r1);
    end
  endtask

  task automatic test_reset_midcycle();
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd3; bus.din = 32'h0BADF00D;
    tick();
    idle();
    @(negedge clk);
    #2;
    bus.wen = 1'b1; bus.rd = 5'd3; bus.din = 32'h55AA55AA;
    bus.rs1 = 5'd3; bus.rs2 = 5'd10;
    rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (bus.r1 !== 32'h0 || bus.r2 !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid r1=%h r2=%h want 0", bus.r1, bus.r2);
    end
    tick();
    checks++;
    if (bus.r1 !== 32'h0 || bus.r2 !== 32'h0) begin
      errors++;
      $display("FAIL rst_edge r1=%h r2=%h want 0", bus.r1, bus.r2);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.r1 !== 32'h0 || bus.r2 !== 32'h0) begin
      errors++;
      $display("FAIL rst_after r1=%h r2=%h want 0", bus.r1, bus.r2);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp;
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd7; bus.din = 32'h11110007;
    tick();
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd7; bus.din = 32'hCAFE0001;
    bus.rs1 = 5'd7;
    #1;
`ifdef WRITE_BYPASS_EN
    exp = 32'hCAFE0001;
`else
    exp = 32'h11110007;
`endif
    checks++;
    if (bus.r1 !== exp) begin
      errors++;
      $display("FAIL bypass_pre r1=%h want %h", bus.r1, exp);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.r1 !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL bypass_post r1=%h want CAFE0001", bus.r1);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.wen = ($urandom_range(0, 3) != 0);
      bus.rd  = AW'($urandom_range(0, 31));
      bus.din = $urandom;
      bus.rs1 = ($urandom_range(0, 2) == 0) ? bus.rd : AW'($urandom_range(0, 31));
      bus.rs2 = AW'($urandom_range(0, 31));
      #1;
      e1 = model_rd(int'(bus.rs1));
      e2 = model_rd(int'(bus.rs2));
      checks++;
      if (bus.r1 !== e1 || bus.r2 !== e2) begin
        errors++;
        $display("FAIL rand_pre n=%0d r1=%h/%h r2=%h/%h", n, bus.r1, e1, bus.r2, e2);
      end
      tick();
      bus.wen = 1'b0;
      #1;
      e1 = model_rd(int'(bus.rs1));
      e2 = model_rd(int'(bus.rs2));
      checks++;
      if (bus.r1 !== e1 || bus.r2 !== e2) begin
        errors++;
        $display("FAIL rand_post n=%0d r1=%h/%h r2=%h/%h", n, bus.r1, e1, bus.r2, e2);
      end
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.rs1 = '0;
    bus.rs2 = '0;
    idle();
    clear_model();
    test_reset();
    test_write();
    test_same_addr();
    test_x0_wen();
    test_reset_midcycle();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
